// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared opcodes, state encoding and helpers for the divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam logic [2:0] DIV_OP  = 3'b100;
    localparam logic [2:0] DIVU_OP = 3'b101;
    localparam logic [2:0] REM_OP  = 3'b110;
    localparam logic [2:0] REMU_OP = 3'b111;

    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Two's-complement magnitude; 32'h80000000 maps to itself and is read as 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational radix-2 restoring division iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step (
    input  logic [32:0] acc,
    input  logic [31:0] dvd,
    input  logic [31:0] divisor,
    output logic [32:0] acc_nxt,
    output logic [31:0] dvd_nxt,
    output logic        q_bit
);

    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;

    always_comb begin
        w_shift = {acc[31:0], dvd[31]};
        w_diff  = w_shift - {1'b0, divisor};
        // A set acc[32] already means the shifted value exceeds any 32-bit divisor.
        w_ge    = acc[32] | (w_shift >= {1'b0, divisor});
        q_bit   = w_ge;
        acc_nxt = w_ge ? w_diff : w_shift;
        dvd_nxt = {dvd[30:0], w_ge};
    end

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Sequential 32-bit DIV/DIVU/REM/REMU unit, 33-cycle latency,
//               single-cycle resolution of divide-by-zero and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  funct3,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        resp_valid,
    output logic [31:0] result
);

    div_state_t  r_state;
    div_state_t  w_state_nxt;
    logic [4:0]  r_count;
    logic [32:0] r_acc;
    logic [31:0] r_dvd;
    logic [31:0] r_divisor;
    logic [31:0] r_result;
    logic        r_want_rem;
    logic        r_neg_q;
    logic        r_neg_r;

    logic        w_accept;
    logic        w_signed;
    logic        w_want_rem;
    logic        w_b_zero;
    logic        w_ovf;
    logic        w_special;
    logic [31:0] w_special_res;
    logic        w_last;
    logic [32:0] w_acc_nxt;
    logic [31:0] w_dvd_nxt;
    logic        w_q_bit;
    logic [31:0] w_q;
    logic [31:0] w_rem;
    logic [31:0] w_final;

    always_comb begin
        w_accept   = req_valid && (r_state == IDLE) && !flush;
        w_signed   = !funct3[0];
        w_want_rem = funct3[1];
        w_b_zero   = (b == 32'd0);
        w_ovf      = w_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        w_special  = w_b_zero || w_ovf;
        if (w_b_zero) begin
            w_special_res = w_want_rem ? a : 32'hFFFF_FFFF;
        end else begin
            w_special_res = w_want_rem ? 32'd0 : 32'h8000_0000;
        end
        w_last = (r_count == 5'(DIV_ITERS - 1));
    end

    div_step u_step (
        .acc     (r_acc),
        .dvd     (r_dvd),
        .divisor (r_divisor),
        .acc_nxt (w_acc_nxt),
        .dvd_nxt (w_dvd_nxt),
        .q_bit   (w_q_bit)
    );

    // Final iteration's values are fixed up directly from the step outputs.
    always_comb begin
        w_q     = {w_dvd_nxt[31:1], w_q_bit};
        w_rem   = w_acc_nxt[31:0];
        if (r_want_rem) begin
            w_final = r_neg_r ? (32'd0 - w_rem) : w_rem;
        end else begin
            w_final = r_neg_q ? (32'd0 - w_q) : w_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        w_state_nxt = w_special ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end
                end
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= 5'd0;
            r_acc      <= 33'd0;
            r_dvd      <= 32'd0;
            r_divisor  <= 32'd0;
            r_result   <= 32'd0;
            r_want_rem <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
        end else if (w_accept) begin
            r_count    <= 5'd0;
            r_acc      <= 33'd0;
            r_dvd      <= w_signed ? abs32(a) : a;
            r_divisor  <= w_signed ? abs32(b) : b;
            r_want_rem <= w_want_rem;
            r_neg_q    <= w_signed && (a[31] ^ b[31]);
            r_neg_r    <= w_signed && a[31];
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if ((r_state == BUSY) && !flush) begin
            r_acc   <= w_acc_nxt;
            r_dvd   <= w_dvd_nxt;
            r_count <= r_count + 5'd1;
            if (w_last) begin
                r_result <= w_final;
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == DONE) && !flush && !rst;
    assign result     = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Scoreboard bench for div_unit: directed corner cases plus
//               randomized ops checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;
    import div_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  funct3 = DIV_OP;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] result;

    exp_t scb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   last_accept = 0;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .funct3     (funct3),
        .a          (a),
        .b          (b),
        .resp_valid (resp_valid),
        .result     (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        logic               ovf;
        sx  = x;
        sy  = y;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (f)
            DIV_OP:  return (y == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sx / sy));
            DIVU_OP: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            REM_OP:  return (y == 0) ? x : (ovf ? 32'd0 : 32'(sx % sy));
            REMU_OP: return (y == 0) ? x : x % y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (y == 0) return 1;
        if (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            exp_t e;
            if (scb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_resp: got result %h at cycle %0d with nothing pending", result, cyc);
            end else begin
                e = scb.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         input string name, input bit track);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_ready_timeout: req_ready got 0 expected 1", name);
        end
        funct3    = f;
        a         = x;
        b         = y;
        req_valid = 1'b1;
        last_accept = cyc;
        if (track) begin
            e.res  = model(f, x, y);
            e.cyc  = cyc + latency(f, x, y);
            e.name = name;
            scb.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
        a         = $urandom;
        b         = $urandom;
        funct3    = 3'($urandom_range(0, 7));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (scb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 100));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, pending %0d", scb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset_result", result, 32'd0);

        issue(DIVU_OP, 32'd100, 32'd7, "divu_100_7", 1'b1);
        drain();
        repeat (3) @(negedge clk);
        check("result_hold", result, 32'd14);
        issue(REMU_OP, 32'd100, 32'd7, "remu_100_7", 1'b1);
        issue(DIV_OP, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 1'b1);
        issue(REM_OP, 32'hFFFF_FFF9, 32'd2, "rem_m7_2", 1'b1);
        issue(REM_OP, 32'd7, 32'hFFFF_FFFE, "rem_7_m2", 1'b1);
        drain();

        issue(DIV_OP, 32'd5, 32'd0, "div_5_0", 1'b1);
        @(negedge clk);
        check("div0_ready_n2", {31'd0, req_ready}, 32'd1);
        issue(REMU_OP, 32'd5, 32'd0, "remu_5_0", 1'b1);
        issue(DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b1);
        issue(REM_OP, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 1'b1);
        issue(DIVU_OP, 32'hFFFF_FFFF, 32'd1, "divu_max_1", 1'b1);
        issue(DIV_OP, 32'h8000_0000, 32'd1, "div_min_1", 1'b1);
        drain();

        // Flush mid-operation: no response, unit idle next cycle, then a fresh op.
        issue(DIVU_OP, 32'd1000, 32'd3, "flushed", 1'b0);
        n = last_accept;
        while (cyc < n + 10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready_n11", {31'd0, req_ready}, 32'd1);
        issue(DIV_OP, 32'd12345, 32'hFFFF_FFEF, "after_flush", 1'b1);
        drain();

        // Reset mid-operation clears the held result.
        issue(DIVU_OP, 32'd999, 32'd10, "reset_victim", 1'b0);
        n = last_accept;
        while (cyc < n + 20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_result", result, 32'd0);
        check("midrst_ready", {31'd0, req_ready}, 32'd1);

        // Flush coincident with a request in IDLE must block the accept.
        @(negedge clk);
        funct3    = DIV_OP;
        a         = 32'd5;
        b         = 32'd0;
        req_valid = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        check("flush_blocks_accept", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b0;
        flush     = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            issue({1'b1, 2'($urandom_range(0, 3))}, rnd_operand(), rnd_operand(), $sformatf("rand%0d", i), 1'b1);
        end
        drain();
        repeat (5) @(negedge clk);
        check("pending_resps", 32'(scb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
